gcn_output_serializer: RTL and testbench

GCN_OUTPUT_SERIALIZER -- requirements
Module: gcn_output_serializer

---
 rtl/gcn_pkg.sv | 22 ++
 rtl/gcn_col_buffer.sv | 27 ++
 rtl/gcn_output_serializer.sv | 128 ++++++++++++
 tb/tb_gcn_output_serializer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/gcn_pkg.sv
// Shared parameters, state encoding and header packing for the GCN output serializer.
package gcn_pkg;

    localparam int unsigned GCN_ROWS = 100;
    localparam int unsigned GCN_DW   = 16;
    localparam int unsigned GCN_CW   = 3;
    localparam int unsigned ROW_AW   = 7;

    typedef enum logic [2:0] {
        StIdle,
        StHeader,
        StData1,
        StData2,
        StDone
    } gcn_state_e;

    // Header word: column index of buffer 2 in the high byte, buffer 1 in the low byte.
    function automatic logic [15:0] make_header(input logic [7:0] col_1, input logic [7:0] col_2);
        return {col_2, col_1};
    endfunction

endpackage

// File: rtl/gcn_col_buffer.sv
// One column buffer: ROWS x DW storage, synchronous write, combinational read, no reset.
module gcn_col_buffer
    import gcn_pkg::*;
#(
    parameter int unsigned ROWS = GCN_ROWS,
    parameter int unsigned DW   = GCN_DW
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ROW_AW-1:0] i_wr_addr,
    input  logic [DW-1:0]     i_wr_data,
    input  logic [ROW_AW-1:0] i_rd_addr,
    output logic [DW-1:0]     o_rd_data
);

    logic [DW-1:0] mem [ROWS];

    // Out-of-range addresses are dropped rather than wrapped onto a valid row.
    always_ff @(posedge clk) begin
        if (i_wr_en && (32'(i_wr_addr) < ROWS)) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/gcn_output_serializer.sv
// Streams a header word followed by both column buffers, one registered word per cycle.
module gcn_output_serializer
    import gcn_pkg::*;
#(
    parameter int unsigned ROWS = GCN_ROWS,
    parameter int unsigned DW   = GCN_DW,
    parameter int unsigned CW   = GCN_CW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic              i_wr_sel,
    input  logic [ROW_AW-1:0] i_wr_addr,
    input  logic [DW-1:0]     i_wr_data,
    input  logic              i_start,
    input  logic [CW-1:0]     i_col_idx_1,
    input  logic [CW-1:0]     i_col_idx_2,
    output logic [DW-1:0]     o_data,
    output logic              o_valid,
    output logic              o_busy,
    output logic              o_rdy
);

    localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(ROWS - 1);

    gcn_state_e        state;
    logic [ROW_AW-1:0] row;
    logic [ROW_AW-1:0] rd_addr;
    logic [DW-1:0]     rd_data_1;
    logic [DW-1:0]     rd_data_2;
    logic [DW-1:0]     header;
    logic              wr_ok;
    logic              last_row;

    assign wr_ok    = i_wr_en && !o_busy;
    assign last_row = (row == LAST_ROW);
    // Look one row ahead so the output register is loaded with the word for the next cycle.
    assign rd_addr  = ((state == StHeader) || last_row) ? '0 : row + 1'b1;
    assign header   = DW'(make_header(8'(i_col_idx_1), 8'(i_col_idx_2)));

    gcn_col_buffer #(
        .ROWS (ROWS),
        .DW   (DW)
    ) u_buf_1 (
        .clk       (clk),
        .i_wr_en   (wr_ok && !i_wr_sel),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_data_1)
    );

    gcn_col_buffer #(
        .ROWS (ROWS),
        .DW   (DW)
    ) u_buf_2 (
        .clk       (clk),
        .i_wr_en   (wr_ok && i_wr_sel),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_data_2)
    );

    // The header word in o_data is the latched copy of both column indices.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StIdle;
            row     <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            o_rdy   <= 1'b0;
        end else begin
            o_rdy <= 1'b0;
            case (state)
                StIdle, StDone: begin
                    row <= '0;
                    if (i_start) begin
                        o_data  <= header;
                        o_valid <= 1'b1;
                        o_busy  <= 1'b1;
                        state   <= StHeader;
                    end else begin
                        o_data  <= '0;
                        o_valid <= 1'b0;
                        o_busy  <= 1'b0;
                        state   <= StIdle;
                    end
                end
                StHeader: begin
                    o_data <= rd_data_1;
                    row    <= '0;
                    state  <= StData1;
                end
                StData1: begin
                    row <= rd_addr;
                    if (last_row) begin
                        o_data <= rd_data_2;
                        state  <= StData2;
                    end else begin
                        o_data <= rd_data_1;
                    end
                end
                StData2: begin
                    row <= rd_addr;
                    if (last_row) begin
                        o_data  <= '0;
                        o_valid <= 1'b0;
                        o_busy  <= 1'b0;
                        o_rdy   <= 1'b1;
                        state   <= StDone;
                    end else begin
                        o_data <= rd_data_2;
                    end
                end
                default: begin
                    row     <= '0;
                    o_data  <= '0;
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                    state   <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcn_output_serializer.sv
// Self-checking bench: streams compared against an array model of both buffers.
module tb_gcn_output_serializer;

    localparam int R = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        wr_sel;
    logic [6:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start;
    logic [2:0]  col_1;
    logic [2:0]  col_2;
    logic [15:0] data;
    logic        valid;
    logic        busy;
    logic        rdy;

    logic [15:0] m1 [R];
    logic [15:0] m2 [R];
    logic [15:0] hdr_exp;
    int n_tests = 0;
    int n_fail  = 0;

    gcn_output_serializer dut (
        .clk         (clk),
        .rst         (rst),
        .i_wr_en     (wr_en),
        .i_wr_sel    (wr_sel),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .i_start     (start),
        .i_col_idx_1 (col_1),
        .i_col_idx_2 (col_2),
        .o_data      (data),
        .o_valid     (valid),
        .o_busy      (busy),
        .o_rdy       (rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input bit sel, input int addr, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = addr[6:0];
        wr_data = d;
        tick();
        wr_en = 1'b0;
        if (addr < R) begin
            if (sel) m2[addr] = d;
            else     m1[addr] = d;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_data"}, 32'(data), 32'h0);
        check({tag, "_valid"}, 32'(valid), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_rdy"}, 32'(rdy), 32'h0);
    endtask

    // issue: pulse start here (else the previous call chained it); chain: start next one from DONE.
    task automatic stream(input bit issue, input bit disturb, input bit chain, input bit wr0);
        logic [15:0] exp;
        if (issue) begin
            start   = 1'b1;
            hdr_exp = {5'b0, col_2, 5'b0, col_1};
            if (wr0) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 7'd0; wr_data = 16'h1234;
                m1[0] = 16'h1234;
            end
            tick();
            start = 1'b0;
            wr_en = 1'b0;
        end
        check("header", 32'(data), 32'(hdr_exp));
        check("hdr_valid", 32'(valid), 32'h1);
        check("hdr_busy", 32'(busy), 32'h1);
        check("hdr_rdy", 32'(rdy), 32'h0);
        for (int i = 0; i < 2 * R; i++) begin
            if (disturb && i == 10) begin
                start = 1'b1;
                col_1 = ~col_1;
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 7'd3; wr_data = 16'hDEAD;
            end
            if (disturb && i == 11) begin
                start = 1'b0;
                wr_en = 1'b0;
            end
            tick();
            exp = (i < R) ? m1[i] : m2[i - R];
            check($sformatf("word%0d", i), 32'(data), 32'(exp));
            check($sformatf("valid%0d", i), 32'(valid), 32'h1);
            check($sformatf("rdy%0d", i), 32'(rdy), 32'h0);
        end
        if (chain) start = 1'b1;
        tick();
        check("done_rdy", 32'(rdy), 32'h1);
        check("done_valid", 32'(valid), 32'h0);
        check("done_data", 32'(data), 32'h0);
        check("done_busy", 32'(busy), 32'h0);
        if (chain) hdr_exp = {5'b0, col_2, 5'b0, col_1};
        tick();
        start = 1'b0;
        if (!chain) check_idle("after_done");
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; col_1 = 3'd2; col_2 = 3'd5; hdr_exp = '0;
        #12;
        check_idle("reset");
        rst = 1'b0;
        tick();

        for (int r = 0; r < R; r++) begin
            load(1'b0, r, 16'(r));
            load(1'b1, r, 16'(16'h8000 + r));
        end
        stream(1'b1, 1'b0, 1'b0, 1'b0);
        check("hdr_const", 32'(hdr_exp), 32'h0502);

        // Out-of-range writes must not alias onto any row.
        load(1'b0, 100, 16'hFFFF);
        load(1'b1, 127, 16'hFFFF);
        stream(1'b1, 1'b0, 1'b0, 1'b0);

        // Ignored start and write while busy.
        stream(1'b1, 1'b1, 1'b0, 1'b0);
        col_1 = 3'd2;
        stream(1'b1, 1'b0, 1'b0, 1'b0);

        // Random contents and indices, some writes out of range.
        for (int k = 0; k < 60; k++) begin
            load(1'($urandom_range(1)), int'($urandom_range(127)), 16'($urandom));
        end
        col_1 = 3'($urandom); col_2 = 3'($urandom);
        stream(1'b1, 1'b0, 1'b0, 1'b0);

        // Abort mid-DATA1 with reset.
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 51; i++) tick();
        check("pre_abort_word", 32'(data), 32'(m1[50]));
        rst = 1'b1;
        #1;
        check_idle("abort");
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_abort_rdy", 32'(rdy), 32'h0);
            check("post_abort_busy", 32'(busy), 32'h0);
        end
        stream(1'b1, 1'b0, 1'b0, 1'b0);

        // Start and row-0 write in the same idle cycle.
        stream(1'b1, 1'b0, 1'b0, 1'b1);

        // Back-to-back: busy low only in the rdy cycle.
        col_1 = 3'd7; col_2 = 3'd1;
        stream(1'b1, 1'b0, 1'b1, 1'b0);
        stream(1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
